dcs_rsp_arb: RTL and testbench
==============================

# dcs_rsp_arb

Round-robin packet arbiter that shares one ECI master channel (header-only or header-plus-data) between `NUM_REQ` DCS slices in the app clock domain. It sits between the per-slice `rsp_wd`/`rsp_wod`/`fwd_wod` master outputs and the shared channel pipeline/CDC towards the ECI link. Each valid/ready transfer carries one complete packet (data, size, VC). The block registers the selected packet in a single output stage and gives fair, one-packet-per-cycle access.

## Interface
- `NUM_REQ`, 2: number of requesting slices, 2..8.
- `DATA_WIDTH`, `ECI_WORD_WIDTH*ECI_PACKET_SIZE`: packet payload width; set to `ECI_WORD_WIDTH` for header-only channels.
- `PERF_REGS_WIDTH`, 32: width of the grant counters.

Ports:
- `clk` in 1: app clock; every signal is synchronous to it.
- `reset` in 1: synchronous, active-high reset.
- `req_pkt_i` in `[NUM_REQ][DATA_WIDTH]`: per-slice packet payload.
- `req_pkt_size_i` in `[NUM_REQ][ECI_PACKET_SIZE_WIDTH]`: per-slice packet size.
- `req_pkt_vc_i` in `[NUM_REQ][4]`: per-slice VC.
- `req_pkt_valid_i` in `NUM_REQ`: per-slice valid.
- `req_pkt_ready_o` out `NUM_REQ`: per-slice ready (one-hot or zero).
- `pkt_o` out `DATA_WIDTH`: registered payload.
- `pkt_size_o` out `ECI_PACKET_SIZE_WIDTH`: registered size.
- `pkt_vc_o` out 4: registered VC.
- `pkt_valid_o` out 1: output valid.
- `pkt_ready_i` in 1: downstream ready.
- `grant_idx_o` out `$clog2(NUM_REQ)`: source slice of the packet currently in the output register.
- `grant_cnt_o` out `[NUM_REQ][PERF_REGS_WIDTH]`: per-slice accepted-packet counters. Present only with `DCS_RSP_ARB_PERF_EN`.

## Operation
- **Output stage:** one register holding {`pkt_o`, `pkt_size_o`, `pkt_vc_o`, `grant_idx_o`} plus `pkt_valid_o`.
- **Accept condition:** `load = !pkt_valid_o | pkt_ready_i`. The register can therefore refill in the same cycle it drains.
- **Arbitration:** combinational round-robin over `req_pkt_valid_i`.
  - The search starts at pointer `rr_ptr` and proceeds upwards, wrapping modulo `NUM_REQ`.
  - The first valid slice found is `gnt`.
- **Ready generation:** `req_pkt_ready_o[i] = load & any_valid & (gnt == i)`. At most one bit is set.
  - `req_pkt_ready_o` may depend on `req_pkt_valid_i`. Upstream must not make valid depend on ready.
- **On a transfer** (`req_pkt_valid_i[gnt] & req_pkt_ready_o[gnt]`):
  - The register loads slice `gnt`'s packet.
  - `pkt_valid_o` is set to 1.
  - `rr_ptr` becomes `(gnt+1) mod NUM_REQ`, computed without relying on power-of-two wrap.
- **`load` with no valid request:**
  - `pkt_valid_o` is cleared to 0.
  - The data register holds its value.
  - `rr_ptr` is unchanged.
- **Stall** (`pkt_valid_o & !pkt_ready_i`): all output fields are held stable and `req_pkt_ready_o` is all zero.
- **Packet integrity:** no packet is dropped, duplicated or reordered within a slice. Packet contents are never modified.
- **Reset values:**
  - `pkt_valid_o`, `pkt_o`, `pkt_size_o`, `pkt_vc_o`, `grant_idx_o` = 0.
  - `rr_ptr` = 0.
  - `req_pkt_ready_o` = 0 while `reset` is high.
  - `grant_cnt_o` = 0.
- **Reset mid-operation:** any packet in the output register is discarded. The next cycle after reset deasserts starts arbitration at slice 0.

## Timing
- **Latency:** 1 cycle from an upstream transfer to `pkt_valid_o`.
- **Throughput:** 1 packet per cycle sustained while `pkt_ready_i` stays high.
- **Fairness:** with all slices continuously valid, grants rotate 0,1,...,`NUM_REQ`-1,0,... A valid slice waits at most `NUM_REQ`-1 granted packets from other slices.
- **Simultaneous drain and refill:** in the same edge, the register is overwritten with the new packet and `pkt_valid_o` stays 1.
- **Single requester:** a lone requester is granted every cycle regardless of `rr_ptr`.
- **No combinational path** from `pkt_ready_i` to the output fields; outputs are registered. The path `pkt_ready_i` → `req_pkt_ready_o` is combinational.

## Configuration
- **`DCS_RSP_ARB_PERF_EN` defined:**
  - `grant_cnt_o[i]` increments by 1 on each transfer from slice `i`.
  - Counters saturate at all-ones; they do not wrap.
  - Counters clear on `reset`.
- **`DCS_RSP_ARB_PERF_EN` undefined:**
  - The `grant_cnt_o` port and the counters are absent.
  - Arbitration behaviour is identical.

## Test plan
- **Reset:** assert `reset` for 3 cycles with all valids high → `pkt_valid_o`=0 and `req_pkt_ready_o`=0 throughout. The first grant after release goes to slice 0.
- **Full contention:** `NUM_REQ`=4, all valid, `pkt_ready_i`=1 for 8 cycles → `grant_idx_o` sequence 0,1,2,3,0,1,2,3, one packet per cycle. Payloads match the sources.
- **Backpressure:** hold `pkt_ready_i`=0 for 5 cycles with the output holding packet A → A stays stable and `req_pkt_ready_o`=0. On release, A is consumed and a new packet is loaded in the same cycle.
- **Sparse requests:** only slice 2 valid, then only slice 1 → slice 2 is granted, then slice 1 is granted immediately; no idle cycle inserted.
- **Reset mid-stall:** assert `reset` while `pkt_valid_o`=1 and `pkt_ready_i`=0 → `pkt_valid_o`=0 next cycle. The packet is not emitted after reset.
- **Counter saturation** (`DCS_RSP_ARB_PERF_EN`, `PERF_REGS_WIDTH`=4): 20 transfers from slice 1 → `grant_cnt_o[1]`=15 and `grant_cnt_o[0]`=0.

Source files
------------

// File: rtl/dcs_rsp_arb.sv
// Round-robin packet arbiter sharing one ECI master channel among NUM_REQ DCS slices.
// Optional grant counters are built only when DCS_RSP_ARB_PERF_EN is defined.
module dcs_rsp_arb #(
    parameter int NUM_REQ               = 2,
    parameter int ECI_WORD_WIDTH        = 64,
    parameter int ECI_PACKET_SIZE       = 17,
    parameter int ECI_PACKET_SIZE_WIDTH = 5,
    parameter int DATA_WIDTH            = ECI_WORD_WIDTH * ECI_PACKET_SIZE,
    parameter int PERF_REGS_WIDTH       = 32
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]            req_pkt_i,
    input  logic [NUM_REQ-1:0][ECI_PACKET_SIZE_WIDTH-1:0] req_pkt_size_i,
    input  logic [NUM_REQ-1:0][3:0]                       req_pkt_vc_i,
    input  logic [NUM_REQ-1:0]                            req_pkt_valid_i,
    output logic [NUM_REQ-1:0]                            req_pkt_ready_o,
    output logic [DATA_WIDTH-1:0]                         pkt_o,
    output logic [ECI_PACKET_SIZE_WIDTH-1:0]              pkt_size_o,
    output logic [3:0]                                    pkt_vc_o,
    output logic                                          pkt_valid_o,
    input  logic                                          pkt_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]                    grant_idx_o
`ifdef DCS_RSP_ARB_PERF_EN
    ,
    output logic [NUM_REQ-1:0][PERF_REGS_WIDTH-1:0]       grant_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt;
    logic [IDX_W-1:0] next_ptr;
    logic             any_valid;
    logic             load;
    logic             xfer;

    // The output register may refill in the same cycle it drains.
    assign load = !pkt_valid_o || pkt_ready_i;
    assign xfer = load && any_valid && !reset;

    // Search upwards from rr_ptr, wrapping explicitly so NUM_REQ need not be a power of two.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        int unsigned cand;
        gnt       = '0;
        any_valid = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_valid && req_pkt_valid_i[cand]) begin
                any_valid = 1'b1;
                gnt       = IDX_W'(cand);
            end
        end
    end

    assign next_ptr = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;

    always_comb begin
        req_pkt_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_pkt_ready_o[i] = xfer && (gnt == IDX_W'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_valid_o <= 1'b0;
            pkt_o       <= '0;
            pkt_size_o  <= '0;
            pkt_vc_o    <= '0;
            grant_idx_o <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            pkt_valid_o <= any_valid;
            if (any_valid) begin
                pkt_o       <= req_pkt_i[gnt];
                pkt_size_o  <= req_pkt_size_i[gnt];
                pkt_vc_o    <= req_pkt_vc_i[gnt];
                grant_idx_o <= gnt;
                rr_ptr      <= next_ptr;
            end
        end
    end

`ifdef DCS_RSP_ARB_PERF_EN
    // Per-slice accepted-packet counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_o <= '0;
        end else if (xfer && (grant_cnt_o[gnt] != {PERF_REGS_WIDTH{1'b1}})) begin
            grant_cnt_o[gnt] <= grant_cnt_o[gnt] + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dcs_rsp_arb.sv
// Directed self-checking bench for dcs_rsp_arb (NUM_REQ=4, narrow payloads).
// Counter checks are compiled in when DCS_RSP_ARB_PERF_EN is defined.
module tb_dcs_rsp_arb;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int SW = 5;
    localparam int PW = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NR-1:0][DW-1:0]     req_pkt_i;
    logic [NR-1:0][SW-1:0]     req_pkt_size_i;
    logic [NR-1:0][3:0]        req_pkt_vc_i;
    logic [NR-1:0]             req_pkt_valid_i;
    logic [NR-1:0]             req_pkt_ready_o;
    logic [DW-1:0]             pkt_o;
    logic [SW-1:0]             pkt_size_o;
    logic [3:0]                pkt_vc_o;
    logic                      pkt_valid_o;
    logic                      pkt_ready_i;
    logic [1:0]                grant_idx_o;
`ifdef DCS_RSP_ARB_PERF_EN
    logic [NR-1:0][PW-1:0]     grant_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dcs_rsp_arb #(
        .NUM_REQ              (NR),
        .ECI_WORD_WIDTH       (DW),
        .ECI_PACKET_SIZE      (1),
        .ECI_PACKET_SIZE_WIDTH(SW),
        .DATA_WIDTH           (DW),
        .PERF_REGS_WIDTH      (PW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_pkt_i      (req_pkt_i),
        .req_pkt_size_i (req_pkt_size_i),
        .req_pkt_vc_i   (req_pkt_vc_i),
        .req_pkt_valid_i(req_pkt_valid_i),
        .req_pkt_ready_o(req_pkt_ready_o),
        .pkt_o          (pkt_o),
        .pkt_size_o     (pkt_size_o),
        .pkt_vc_o       (pkt_vc_o),
        .pkt_valid_o    (pkt_valid_o),
        .pkt_ready_i    (pkt_ready_i),
        .grant_idx_o    (grant_idx_o)
`ifdef DCS_RSP_ARB_PERF_EN
        ,
        .grant_cnt_o    (grant_cnt_o)
`endif
    );

    function automatic logic [DW-1:0] pl(input int i);
        return DW'(16'h1000 * (i + 1) + 16'h00A5);
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_payloads();
        for (int i = 0; i < NR; i++) begin
            req_pkt_i[i]      = pl(i);
            req_pkt_size_i[i] = SW'(i + 1);
            req_pkt_vc_i[i]   = 4'(i + 4);
        end
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        req_pkt_valid_i = '0;
        pkt_ready_i     = 1'b0;
        load_payloads();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset           = 1'b1;
        req_pkt_valid_i = 4'hF;
        pkt_ready_i     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (req_pkt_ready_o !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_ready[%0d]: got %b expected 0000", c, req_pkt_ready_o);
            end
            step();
            n_cmp++;
            if (pkt_valid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_valid[%0d]: got %b expected 0", c, pkt_valid_o);
            end
        end
        n_cmp++;
        if (pkt_o !== '0 || pkt_size_o !== '0 || pkt_vc_o !== '0 || grant_idx_o !== '0) begin
            n_bad++;
            $display("FAIL reset_fields: got %h/%h/%h/%h expected all zero",
                     pkt_o, pkt_size_o, pkt_vc_o, grant_idx_o);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (req_pkt_ready_o !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_first_ready: got %b expected 0001", req_pkt_ready_o);
        end
        step();
        n_cmp++;
        if (pkt_valid_o !== 1'b1 || grant_idx_o !== 2'd0 || pkt_o !== pl(0)) begin
            n_bad++;
            $display("FAIL reset_first_grant: got v=%b idx=%0d pkt=%h expected v=1 idx=0 pkt=%h",
                     pkt_valid_o, grant_idx_o, pkt_o, pl(0));
        end
    endtask

    task automatic test_full_contention();
        do_reset();
        req_pkt_valid_i = 4'hF;
        pkt_ready_i     = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_cmp++;
            if (req_pkt_ready_o !== 4'(1 << (c % NR))) begin
                n_bad++;
                $display("FAIL contention_ready[%0d]: got %b expected %b",
                         c, req_pkt_ready_o, 4'(1 << (c % NR)));
            end
            step();
            n_cmp++;
            if (pkt_valid_o !== 1'b1 || grant_idx_o !== 2'(c % NR) || pkt_o !== pl(c % NR)
                || pkt_size_o !== SW'(c % NR + 1) || pkt_vc_o !== 4'(c % NR + 4)) begin
                n_bad++;
                $display("FAIL contention_out[%0d]: got v=%b idx=%0d pkt=%h sz=%0d vc=%0d expected v=1 idx=%0d pkt=%h sz=%0d vc=%0d",
                         c, pkt_valid_o, grant_idx_o, pkt_o, pkt_size_o, pkt_vc_o,
                         c % NR, pl(c % NR), c % NR + 1, c % NR + 4);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_pkt_valid_i = 4'b0011;
        pkt_ready_i     = 1'b0;
        step();
        // Changing slice 0's input shows whether the held packet gets overwritten.
        req_pkt_i[0] = 16'hDEAD;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (req_pkt_ready_o !== 4'b0000) begin
                n_bad++;
                $display("FAIL stall_ready[%0d]: got %b expected 0000", c, req_pkt_ready_o);
            end
            n_cmp++;
            if (pkt_valid_o !== 1'b1 || grant_idx_o !== 2'd0 || pkt_o !== pl(0)) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got v=%b idx=%0d pkt=%h expected v=1 idx=0 pkt=%h",
                         c, pkt_valid_o, grant_idx_o, pkt_o, pl(0));
            end
            step();
        end
        pkt_ready_i = 1'b1;
        #1;
        n_cmp++;
        if (req_pkt_ready_o !== 4'b0010) begin
            n_bad++;
            $display("FAIL release_ready: got %b expected 0010", req_pkt_ready_o);
        end
        step();
        n_cmp++;
        if (pkt_valid_o !== 1'b1 || grant_idx_o !== 2'd1 || pkt_o !== pl(1)) begin
            n_bad++;
            $display("FAIL release_refill: got v=%b idx=%0d pkt=%h expected v=1 idx=1 pkt=%h",
                     pkt_valid_o, grant_idx_o, pkt_o, pl(1));
        end
    endtask

    task automatic test_sparse();
        do_reset();
        pkt_ready_i     = 1'b1;
        req_pkt_valid_i = 4'b0100;
        #1;
        n_cmp++;
        if (req_pkt_ready_o !== 4'b0100) begin
            n_bad++;
            $display("FAIL sparse_ready2: got %b expected 0100", req_pkt_ready_o);
        end
        step();
        n_cmp++;
        if (pkt_valid_o !== 1'b1 || grant_idx_o !== 2'd2 || pkt_o !== pl(2)) begin
            n_bad++;
            $display("FAIL sparse_grant2: got v=%b idx=%0d pkt=%h expected v=1 idx=2 pkt=%h",
                     pkt_valid_o, grant_idx_o, pkt_o, pl(2));
        end
        req_pkt_valid_i = 4'b0010;
        #1;
        n_cmp++;
        if (req_pkt_ready_o !== 4'b0010) begin
            n_bad++;
            $display("FAIL sparse_ready1: got %b expected 0010", req_pkt_ready_o);
        end
        step();
        n_cmp++;
        if (pkt_valid_o !== 1'b1 || grant_idx_o !== 2'd1 || pkt_o !== pl(1)) begin
            n_bad++;
            $display("FAIL sparse_grant1: got v=%b idx=%0d pkt=%h expected v=1 idx=1 pkt=%h",
                     pkt_valid_o, grant_idx_o, pkt_o, pl(1));
        end
        req_pkt_valid_i = 4'b0000;
        step();
        n_cmp++;
        if (pkt_valid_o !== 1'b0 || pkt_o !== pl(1)) begin
            n_bad++;
            $display("FAIL sparse_idle: got v=%b pkt=%h expected v=0 pkt=%h",
                     pkt_valid_o, pkt_o, pl(1));
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        req_pkt_valid_i = 4'b0001;
        pkt_ready_i     = 1'b0;
        step();
        req_pkt_valid_i = 4'b0000;
        step();
        n_cmp++;
        if (pkt_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL midstall_pre: got v=%b expected 1", pkt_valid_o);
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if (pkt_valid_o !== 1'b0 || pkt_o !== '0) begin
            n_bad++;
            $display("FAIL midstall_reset: got v=%b pkt=%h expected v=0 pkt=0000", pkt_valid_o, pkt_o);
        end
        reset       = 1'b0;
        pkt_ready_i = 1'b1;
        step();
        n_cmp++;
        if (pkt_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL midstall_no_reemit: got v=%b expected 0", pkt_valid_o);
        end
        req_pkt_valid_i = 4'hF;
        #1;
        n_cmp++;
        if (req_pkt_ready_o !== 4'b0001) begin
            n_bad++;
            $display("FAIL midstall_ptr: got %b expected 0001", req_pkt_ready_o);
        end
        step();
    endtask

`ifdef DCS_RSP_ARB_PERF_EN
    task automatic test_counters();
        do_reset();
        req_pkt_valid_i = 4'b0010;
        pkt_ready_i     = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c == 4) begin
                n_cmp++;
                if (grant_cnt_o[1] !== 4'd5) begin
                    n_bad++;
                    $display("FAIL cnt_mid: got %0d expected 5", grant_cnt_o[1]);
                end
            end
        end
        n_cmp++;
        if (grant_cnt_o[1] !== 4'd15 || grant_cnt_o[0] !== 4'd0) begin
            n_bad++;
            $display("FAIL cnt_sat: got c1=%0d c0=%0d expected c1=15 c0=0",
                     grant_cnt_o[1], grant_cnt_o[0]);
        end
    endtask
`endif

    initial begin
        reset           = 1'b1;
        req_pkt_valid_i = '0;
        pkt_ready_i     = 1'b0;
        load_payloads();
        test_reset();
        test_full_contention();
        test_backpressure();
        test_sparse();
        test_reset_mid_stall();
`ifdef DCS_RSP_ARB_PERF_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
